// File: rtl/dds_seq_pkg.sv
// Shared definitions for the DDS table-load sequencer: FSM encoding, table
// addresses, control-register bit positions and the tone-count legality check.
package dds_seq_pkg;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE = 3'd0;
   localparam state_t S_SRST = 3'd1;
   localparam state_t S_LOAD = 3'd2;
   localparam state_t S_WR_T = 3'd3;
   localparam state_t S_WR_D = 3'd4;
   localparam state_t S_WR_A = 3'd5;
   localparam state_t S_RUN  = 3'd6;

   localparam logic [31:0] ADDR_THETAS = 32'd0;
   localparam logic [31:0] ADDR_DELTAS = 32'd1;
   localparam logic [31:0] ADDR_AMPLS  = 32'd2;

   localparam int CTRL_SRST_BIT  = 0;
   localparam int CTRL_START_BIT = 1;

   // The DDS core only supports these table lengths
   function automatic logic num_tones_legal(input logic [8:0] n);
      case (n)
         9'd1, 9'd8, 9'd16, 9'd32, 9'd64, 9'd128, 9'd256: return 1'b1;
         default:                                          return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/dds_seq_tick.sv
// Sample divider: counts 0..div_i-1 while enabled and pulses on the last count.
// Counter is held at 0 while disabled so the first pulse comes div_i cycles in.
module dds_seq_tick #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 a_rst_n,
   input  logic                 en_i,
   input  logic [CNT_WIDTH-1:0] div_i,
   output logic                 pulse_o
);

   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 last;

   assign last    = (cnt_q == div_i - CNT_WIDTH'(1));
   assign pulse_o = en_i && last;

   always_comb begin
      cnt_d = '0;
      if (en_i && !last) cnt_d = cnt_q + CNT_WIDTH'(1);
   end

   always_ff @(posedge clk or negedge a_rst_n) begin
      if (!a_rst_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

endmodule

// File: rtl/dds_seq.sv
// DDS table-load sequencer: soft-resets the DDS, writes theta/delta/ampl per tone,
// then runs the sample divider. Optional burst mode under DDS_SEQ_BURST_EN.
module dds_seq
   import dds_seq_pkg::*;
#(
   parameter int SIG_WIDTH = 16,
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 a_rst_n,
   input  logic                 cfg_start,
   input  logic                 cfg_stop,
   input  logic [8:0]           cfg_num_tones,
   input  logic [CNT_WIDTH-1:0] cfg_clk_div,
`ifdef DDS_SEQ_BURST_EN
   input  logic [CNT_WIDTH-1:0] cfg_burst_len,
`endif
   input  logic                 tone_valid,
   output logic                 tone_ready,
   input  logic [SIG_WIDTH-1:0] tone_theta,
   input  logic [SIG_WIDTH-1:0] tone_delta,
   input  logic [SIG_WIDTH-1:0] tone_ampl,
   output logic [31:0]          o_dds_addrs,
   output logic                 o_dds_write,
   output logic [31:0]          o_dds_thetas_reg,
   output logic [31:0]          o_dds_deltas_reg,
   output logic [31:0]          o_dds_ampls_reg,
   output logic [31:0]          o_dds_ctrl_reg,
   output logic [31:0]          o_dds_lngth_reg,
   output logic [31:0]          o_dds_clk_div_reg,
   output logic                 o_dds_sample_en,
   output logic                 o_busy,
   output logic                 o_running,
   output logic                 o_err
);

   localparam int CW1 = CNT_WIDTH + 1;

   state_t               state_q, state_d;
   logic [8:0]           tone_cnt_q, tone_cnt_d;
   logic [8:0]           num_tones_q;
   logic [CNT_WIDTH-1:0] clk_div_q;
   logic [SIG_WIDTH-1:0] theta_q, delta_q, ampl_q;
   logic                 err_q, err_d;
   logic                 start_cmd, cfg_legal, latch_cfg, capture;
   logic                 tick, burst_done;
   logic [CW1-1:0]       min_div;

   // Stop wins over a simultaneous start
   assign start_cmd = cfg_start && !cfg_stop;
   assign min_div   = CW1'(cfg_num_tones) + CW1'(4);
   assign cfg_legal = num_tones_legal(cfg_num_tones) && ({1'b0, cfg_clk_div} >= min_div);
   assign latch_cfg = (state_q == S_IDLE) && start_cmd && cfg_legal;
   assign capture   = (state_q == S_LOAD) && tone_valid;

`ifdef DDS_SEQ_BURST_EN
   logic [CNT_WIDTH-1:0] burst_q, burst_cnt_q;

   assign burst_done = tick && (burst_q != '0) && (burst_cnt_q + CNT_WIDTH'(1) == burst_q);

   always_ff @(posedge clk or negedge a_rst_n) begin
      if (!a_rst_n) begin
         burst_q     <= '0;
         burst_cnt_q <= '0;
      end else begin
         if (latch_cfg) burst_q <= cfg_burst_len;
         if (state_q != S_RUN) burst_cnt_q <= '0;
         else if (tick)        burst_cnt_q <= burst_cnt_q + CNT_WIDTH'(1);
      end
   end
`else
   assign burst_done = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      tone_cnt_d = tone_cnt_q;
      err_d      = err_q;
      case (state_q)
         S_IDLE: begin
            tone_cnt_d = '0;
            if (start_cmd) begin
               err_d = !cfg_legal;
               if (cfg_legal) state_d = S_SRST;
            end
         end
         S_SRST: state_d = S_LOAD;
         S_LOAD: if (tone_valid) state_d = S_WR_T;
         S_WR_T: state_d = S_WR_D;
         S_WR_D: state_d = S_WR_A;
         S_WR_A: begin
            tone_cnt_d = tone_cnt_q + 9'd1;
            state_d    = (tone_cnt_d == num_tones_q) ? S_RUN : S_LOAD;
         end
         S_RUN:   if (burst_done) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (cfg_stop && state_q != S_IDLE) state_d = S_IDLE;
   end

   always_ff @(posedge clk or negedge a_rst_n) begin
      if (!a_rst_n) begin
         state_q     <= S_IDLE;
         tone_cnt_q  <= '0;
         num_tones_q <= '0;
         clk_div_q   <= '0;
         theta_q     <= '0;
         delta_q     <= '0;
         ampl_q      <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         tone_cnt_q <= tone_cnt_d;
         err_q      <= err_d;
         if (latch_cfg) begin
            num_tones_q <= cfg_num_tones;
            clk_div_q   <= cfg_clk_div;
         end
         if (capture) begin
            theta_q <= tone_theta;
            delta_q <= tone_delta;
            ampl_q  <= tone_ampl;
         end
      end
   end

   dds_seq_tick #(.CNT_WIDTH(CNT_WIDTH)) u_tick (
      .clk     (clk),
      .a_rst_n (a_rst_n),
      .en_i    (state_q == S_RUN),
      .div_i   (clk_div_q),
      .pulse_o (tick)
   );

   // Data ports carry a field only during its write cycle, zero otherwise
   always_comb begin
      o_dds_addrs      = '0;
      o_dds_thetas_reg = '0;
      o_dds_deltas_reg = '0;
      o_dds_ampls_reg  = '0;
      o_dds_ctrl_reg   = '0;
      case (state_q)
         S_WR_T: begin
            o_dds_addrs      = ADDR_THETAS;
            o_dds_thetas_reg = 32'($signed(theta_q));
         end
         S_WR_D: begin
            o_dds_addrs      = ADDR_DELTAS;
            o_dds_deltas_reg = 32'($signed(delta_q));
         end
         S_WR_A: begin
            o_dds_addrs     = ADDR_AMPLS;
            o_dds_ampls_reg = 32'($signed(ampl_q));
         end
         default: ;
      endcase
      o_dds_ctrl_reg[CTRL_SRST_BIT]  = (state_q == S_SRST);
      o_dds_ctrl_reg[CTRL_START_BIT] = (state_q == S_RUN);
   end

   assign tone_ready        = (state_q == S_LOAD);
   assign o_dds_write       = (state_q == S_WR_T) || (state_q == S_WR_D) || (state_q == S_WR_A);
   assign o_dds_lngth_reg   = 32'(num_tones_q);
   assign o_dds_clk_div_reg = 32'(clk_div_q);
   assign o_dds_sample_en   = tick;
   assign o_busy            = (state_q != S_IDLE);
   assign o_running         = (state_q == S_RUN);
   assign o_err             = err_q;

endmodule

// File: tb/tb_dds_seq.sv
// Directed bench for dds_seq: reset, single/multi-tone loads, config errors,
// stop handling, reset during RUN and (with DDS_SEQ_BURST_EN) burst mode.
module tb_dds_seq;

   logic        clk = 1'b0;
   logic        a_rst_n = 1'b0;
   logic        cfg_start = 1'b0, cfg_stop = 1'b0;
   logic [8:0]  cfg_num_tones = '0;
   logic [31:0] cfg_clk_div = '0;
   logic [31:0] cfg_burst_len = '0;
   logic        tone_valid = 1'b0;
   logic        tone_ready;
   logic [15:0] tone_theta = '0, tone_delta = '0, tone_ampl = '0;
   logic [31:0] o_dds_addrs, o_dds_thetas_reg, o_dds_deltas_reg, o_dds_ampls_reg;
   logic [31:0] o_dds_ctrl_reg, o_dds_lngth_reg, o_dds_clk_div_reg;
   logic        o_dds_write, o_dds_sample_en, o_busy, o_running, o_err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   dds_seq dut (
      .clk               (clk),
      .a_rst_n           (a_rst_n),
      .cfg_start         (cfg_start),
      .cfg_stop          (cfg_stop),
      .cfg_num_tones     (cfg_num_tones),
      .cfg_clk_div       (cfg_clk_div),
`ifdef DDS_SEQ_BURST_EN
      .cfg_burst_len     (cfg_burst_len),
`endif
      .tone_valid        (tone_valid),
      .tone_ready        (tone_ready),
      .tone_theta        (tone_theta),
      .tone_delta        (tone_delta),
      .tone_ampl         (tone_ampl),
      .o_dds_addrs       (o_dds_addrs),
      .o_dds_write       (o_dds_write),
      .o_dds_thetas_reg  (o_dds_thetas_reg),
      .o_dds_deltas_reg  (o_dds_deltas_reg),
      .o_dds_ampls_reg   (o_dds_ampls_reg),
      .o_dds_ctrl_reg    (o_dds_ctrl_reg),
      .o_dds_lngth_reg   (o_dds_lngth_reg),
      .o_dds_clk_div_reg (o_dds_clk_div_reg),
      .o_dds_sample_en   (o_dds_sample_en),
      .o_busy            (o_busy),
      .o_running         (o_running),
      .o_err             (o_err)
   );

   // Outputs are sampled 1 time unit after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [255:0] outs;
      #1;
      outs = {o_dds_addrs, o_dds_thetas_reg, o_dds_deltas_reg, o_dds_ampls_reg,
              o_dds_ctrl_reg, o_dds_lngth_reg, o_dds_clk_div_reg,
              o_dds_write, o_dds_sample_en, o_busy, o_running, o_err, tone_ready, 2'b00};
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h want 0", outs);
      end
      step();
      a_rst_n = 1'b1;
      step();
      checks++;
      if (o_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: busy=%b want 0", o_busy);
      end
   endtask

   // Load one tone and check the write sequence and sample_en cadence; leaves DUT in RUN
   task automatic run_single(input logic [31:0] div, input logic [15:0] th, de, am);
      cfg_num_tones = 9'd1;
      cfg_clk_div   = div;
      cfg_start     = 1'b1;
      step();
      cfg_start = 1'b0;
      checks++;
      if (o_dds_ctrl_reg !== 32'd1 || o_dds_lngth_reg !== 32'd1 || o_dds_clk_div_reg !== div ||
          o_busy !== 1'b1 || tone_ready !== 1'b0) begin
         errors++;
         $display("FAIL srst: ctrl=%h lngth=%h div=%h busy=%b rdy=%b want 1/1/%h/1/0",
                  o_dds_ctrl_reg, o_dds_lngth_reg, o_dds_clk_div_reg, o_busy, tone_ready, div);
      end
      tone_valid = 1'b1;
      tone_theta = th;
      tone_delta = de;
      tone_ampl  = am;
      step();
      checks++;
      if (tone_ready !== 1'b1 || o_dds_ctrl_reg !== 32'd0 || o_dds_write !== 1'b0) begin
         errors++;
         $display("FAIL load: rdy=%b ctrl=%h wr=%b want 1/0/0", tone_ready, o_dds_ctrl_reg, o_dds_write);
      end
      step();
      tone_valid = 1'b0;
      checks++;
      if (o_dds_write !== 1'b1 || o_dds_addrs !== 32'd0 || o_dds_thetas_reg !== {16'h0, th} ||
          o_dds_deltas_reg !== 32'd0 || tone_ready !== 1'b0) begin
         errors++;
         $display("FAIL wr_theta: wr=%b addr=%h data=%h d=%h want 1/0/%h/0",
                  o_dds_write, o_dds_addrs, o_dds_thetas_reg, o_dds_deltas_reg, th);
      end
      step();
      checks++;
      if (o_dds_write !== 1'b1 || o_dds_addrs !== 32'd1 || o_dds_deltas_reg !== {16'h0, de}) begin
         errors++;
         $display("FAIL wr_delta: wr=%b addr=%h data=%h want 1/1/%h", o_dds_write, o_dds_addrs, o_dds_deltas_reg, de);
      end
      step();
      checks++;
      if (o_dds_write !== 1'b1 || o_dds_addrs !== 32'd2 || o_dds_ampls_reg !== {16'h0, am}) begin
         errors++;
         $display("FAIL wr_ampl: wr=%b addr=%h data=%h want 1/2/%h", o_dds_write, o_dds_addrs, o_dds_ampls_reg, am);
      end
      step();
      checks++;
      if (o_running !== 1'b1 || o_dds_ctrl_reg !== 32'd2 || o_dds_write !== 1'b0) begin
         errors++;
         $display("FAIL run_entry: run=%b ctrl=%h wr=%b want 1/2/0", o_running, o_dds_ctrl_reg, o_dds_write);
      end
      for (int i = 0; i < 2 * int'(div); i++) begin
         checks++;
         if (o_dds_sample_en !== ((i % int'(div)) == int'(div) - 1)) begin
            errors++;
            $display("FAIL sample_en_cadence: cycle %0d got %b want %b", i, o_dds_sample_en,
                     (i % int'(div)) == int'(div) - 1);
         end
         if (i + 1 < 2 * int'(div)) step();
      end
   endtask

   task automatic check_quiet(input string name);
      int bad = 0;
      checks++;
      if (o_busy !== 1'b0 || o_dds_ctrl_reg !== 32'd0 || o_running !== 1'b0 || tone_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s_idle: busy=%b ctrl=%h run=%b rdy=%b want 0/0/0/0",
                  name, o_busy, o_dds_ctrl_reg, o_running, tone_ready);
      end
      for (int i = 0; i < 20; i++) begin
         if (o_dds_write || o_dds_sample_en) bad++;
         step();
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL %s_quiet: %0d active cycles want 0", name, bad);
      end
   endtask

   task automatic test_basic();
      run_single(32'd8, 16'h1000, 16'h0200, 16'h4000);
      cfg_stop = 1'b1;
      step();
      cfg_stop = 1'b0;
      check_quiet("basic_stop");
   endtask

   task automatic test_multi_tone();
      int wr = 0, rdy = 0, run_at = -1;
      cfg_num_tones = 9'd8;
      cfg_clk_div   = 32'd12;
      tone_theta    = 16'hF000;
      tone_delta    = 16'h0001;
      tone_ampl     = 16'h7FFF;
      tone_valid    = 1'b1;
      cfg_start     = 1'b1;
      step();
      cfg_start = 1'b0;
      for (int c = 0; c < 60; c++) begin
         if (o_running) begin
            run_at = c;
            break;
         end
         if (tone_ready) rdy++;
         if (o_dds_write) begin
            wr++;
            checks++;
            if (tone_ready !== 1'b0) begin
               errors++;
               $display("FAIL ready_in_write: cycle %0d rdy=%b want 0", c, tone_ready);
            end
            if (o_dds_addrs == 32'd0) begin
               checks++;
               if (o_dds_thetas_reg !== 32'hFFFF_F000) begin
                  errors++;
                  $display("FAIL theta_signext: got %h want ffff_f000", o_dds_thetas_reg);
               end
            end
         end
         step();
      end
      tone_valid = 1'b0;
      checks++;
      if (wr != 24 || rdy != 8 || run_at != 33) begin
         errors++;
         $display("FAIL multi_tone: writes=%0d ready=%0d run_at=%0d want 24/8/33", wr, rdy, run_at);
      end
      cfg_start = 1'b1;
      cfg_stop  = 1'b1;
      step();
      cfg_start = 1'b0;
      cfg_stop  = 1'b0;
      check_quiet("start_stop_run");
   endtask

   task automatic test_cfg_err();
      cfg_num_tones = 9'd5;
      cfg_clk_div   = 32'd100;
      cfg_start     = 1'b1;
      step();
      cfg_start = 1'b0;
      checks++;
      if (o_err !== 1'b1 || o_busy !== 1'b0 || o_dds_ctrl_reg !== 32'd0) begin
         errors++;
         $display("FAIL err_len5: err=%b busy=%b ctrl=%h want 1/0/0", o_err, o_busy, o_dds_ctrl_reg);
      end
      step();
      checks++;
      if (o_err !== 1'b1) begin
         errors++;
         $display("FAIL err_sticky: err=%b want 1", o_err);
      end
      cfg_num_tones = 9'd1;
      cfg_clk_div   = 32'd4;
      cfg_start     = 1'b1;
      step();
      cfg_start = 1'b0;
      checks++;
      if (o_err !== 1'b1 || o_busy !== 1'b0 || o_dds_ctrl_reg !== 32'd0) begin
         errors++;
         $display("FAIL err_div4: err=%b busy=%b ctrl=%h want 1/0/0", o_err, o_busy, o_dds_ctrl_reg);
      end
      // clk_div exactly num_tones+4 is the smallest legal divider
      cfg_clk_div = 32'd5;
      cfg_start   = 1'b1;
      step();
      cfg_start = 1'b0;
      checks++;
      if (o_err !== 1'b0 || o_busy !== 1'b1 || o_dds_ctrl_reg !== 32'd1) begin
         errors++;
         $display("FAIL div_min_legal: err=%b busy=%b ctrl=%h want 0/1/1", o_err, o_busy, o_dds_ctrl_reg);
      end
      cfg_stop = 1'b1;
      step();
      cfg_stop = 1'b0;
      check_quiet("stop_srst");
   endtask

   task automatic test_stop_load();
      int wr = 0;
      bit hit = 0;
      cfg_num_tones = 9'd8;
      cfg_clk_div   = 32'd20;
      tone_theta    = 16'h0123;
      tone_valid    = 1'b1;
      cfg_start     = 1'b1;
      step();
      cfg_start = 1'b0;
      for (int c = 0; c < 60; c++) begin
         if (o_dds_write) wr++;
         if (tone_ready && wr == 9) begin
            hit = 1;
            break;
         end
         step();
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL stop_load_reach: writes=%0d want 9 before LOAD", wr);
      end
      cfg_stop   = 1'b1;
      tone_valid = 1'b0;
      step();
      cfg_stop = 1'b0;
      check_quiet("stop_load");
   endtask

   task automatic test_reset_run();
      logic [255:0] outs;
      run_single(32'd8, 16'h0ABC, 16'h0011, 16'h0022);
      step();
      step();
      a_rst_n = 1'b0;
      #1;
      outs = {o_dds_addrs, o_dds_thetas_reg, o_dds_deltas_reg, o_dds_ampls_reg,
              o_dds_ctrl_reg, o_dds_lngth_reg, o_dds_clk_div_reg,
              o_dds_write, o_dds_sample_en, o_busy, o_running, o_err, tone_ready, 2'b00};
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL reset_in_run: got %h want 0", outs);
      end
      step();
      a_rst_n = 1'b1;
      step();
      run_single(32'd8, 16'h1000, 16'h0200, 16'h4000);
      cfg_stop = 1'b1;
      step();
      cfg_stop = 1'b0;
      check_quiet("restart_stop");
   endtask

`ifdef DDS_SEQ_BURST_EN
   task automatic test_burst();
      int pulses = 0, idle_at = -1, run_c = -1;
      cfg_burst_len = 32'd3;
      cfg_num_tones = 9'd1;
      cfg_clk_div   = 32'd10;
      tone_valid    = 1'b1;
      cfg_start     = 1'b1;
      step();
      cfg_start = 1'b0;
      for (int c = 0; c < 20 && run_c < 0; c++) begin
         if (o_running) run_c = c;
         else step();
      end
      tone_valid = 1'b0;
      for (int c = 0; c < 60; c++) begin
         if (!o_busy) begin
            idle_at = c;
            break;
         end
         if (o_dds_sample_en) pulses++;
         step();
      end
      checks++;
      if (run_c < 0 || pulses != 3 || idle_at != 30) begin
         errors++;
         $display("FAIL burst: run=%0d pulses=%0d idle_at=%0d want 3/30", run_c, pulses, idle_at);
      end
      cfg_burst_len = 32'd0;
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_multi_tone();
      test_cfg_err();
      test_stop_load();
      test_reset_run();
`ifdef DDS_SEQ_BURST_EN
      test_burst();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
